// File: rtl/pwm_meter.sv
// pwm_meter: measures high time and period (in clk cycles) of a PWM
// waveform, one measurement per complete period, and flags a waveform
// that stays high or low for longer than TIMEOUT cycles.
//
// Optional feature: define PWM_METER_FILTER_EN to insert a glitch filter
// between the synchronizer and the edge detector. The filter drops any
// pulse shorter than FILTER_LEN cycles. Without the macro, the
// synchronized input feeds the edge detector directly.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            synchronous active-high reset
//   sig_in         PWM input, asynchronous to clk
//   high_cycles    high time of the last complete period
//   period_cycles  high + low time of the last complete period
//   meas_valid     one-cycle strobe; high_cycles/period_cycles updated
//   stuck_high     sticky; input held high too long (cleared by next measurement)
//   stuck_low      sticky; input held low too long (cleared by next measurement)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | discard partial period; wait for a clean fall, track high run
// ST_WAIT | input low after first fall, no high phase captured yet
// ST_HIGH | counting high phase of the period being measured
// ST_LOW  | counting low phase; next rise publishes the measurement

module pwm_meter #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W:0]   period_cycles,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  if ((TIMEOUT < 2) || (TIMEOUT > (2**CNT_W) - 1) || (FILTER_LEN < 1)) begin : g_param_check
    $error("pwm_meter: TIMEOUT or FILTER_LEN out of legal range");
  end

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HIGH, ST_LOW} state_t;

  logic sync_q1;
  logic sig_s;
  logic sig_f;
  logic sig_d;
  logic rise;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sig_s   <= 1'b0;
    end else begin
      sync_q1 <= sig_in;
      sig_s   <= sync_q1;
    end
  end

`ifdef PWM_METER_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt;

  // sig_f follows sig_s only once they have disagreed for FILTER_LEN
  // consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt <= '0;
      sig_f   <= 1'b0;
    end else if (sig_s != sig_f) begin
      if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        sig_f   <= sig_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end else begin
      flt_cnt <= '0;
    end
  end
`else
  assign sig_f = sig_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig_f;
  end

  assign rise = sig_f & ~sig_d;
  assign fall = ~sig_f & sig_d;

  state_t           state, state_n;
  logic [CNT_W-1:0] hi_cnt, hi_n;
  logic [CNT_W-1:0] lo_cnt, lo_n;
  logic [CNT_W-1:0] high_n;
  logic [CNT_W:0]   period_n;
  logic             valid_n;
  logic             sh_n;
  logic             sl_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      hi_cnt        <= '0;
      lo_cnt        <= '0;
      high_cycles   <= '0;
      period_cycles <= '0;
      meas_valid    <= 1'b0;
      stuck_high    <= 1'b0;
      stuck_low     <= 1'b0;
    end else begin
      state         <= state_n;
      hi_cnt        <= hi_n;
      lo_cnt        <= lo_n;
      high_cycles   <= high_n;
      period_cycles <= period_n;
      meas_valid    <= valid_n;
      stuck_high    <= sh_n;
      stuck_low     <= sl_n;
    end
  end

  // Edges are tested before the timeout compare so that an edge arriving
  // on the timeout cycle wins. Counters leave their state on reaching TO,
  // so they saturate at TO and never wrap.
  always_comb begin
    state_n  = state;
    hi_n     = hi_cnt;
    lo_n     = lo_cnt;
    high_n   = high_cycles;
    period_n = period_cycles;
    valid_n  = 1'b0;
    sh_n     = stuck_high;
    sl_n     = stuck_low;

    case (state)
      ST_IDLE: begin
        // A rise here (including the one seen at reset release) is ignored;
        // hi_cnt only tracks how long the input has been high.
        if (fall) begin
          state_n = ST_WAIT;
          lo_n    = ONE;
          hi_n    = '0;
        end else if (hi_cnt == TO) begin
          sh_n = 1'b1;
        end else if (sig_f) begin
          hi_n = hi_cnt + 1'b1;
        end else begin
          hi_n = '0;
        end
      end

      ST_WAIT: begin
        if (rise) begin
          state_n = ST_HIGH;
          hi_n    = ONE;
          lo_n    = '0;
        end else if (lo_cnt == TO) begin
          state_n = ST_IDLE;
          sl_n    = 1'b1;
          hi_n    = '0;
          lo_n    = '0;
        end else begin
          lo_n = lo_cnt + 1'b1;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_n = ST_LOW;
          lo_n    = ONE;
        end else if (hi_cnt == TO) begin
          // hi_cnt stays at TO: in ST_IDLE it means "high for TO cycles".
          state_n = ST_IDLE;
          sh_n    = 1'b1;
          lo_n    = '0;
        end else begin
          hi_n = hi_cnt + 1'b1;
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_n  = ST_HIGH;
          high_n   = hi_cnt;
          period_n = {1'b0, hi_cnt} + {1'b0, lo_cnt};
          valid_n  = 1'b1;
          sh_n     = 1'b0;
          sl_n     = 1'b0;
          hi_n     = ONE;
          lo_n     = '0;
        end else if (lo_cnt == TO) begin
          state_n = ST_IDLE;
          sl_n    = 1'b1;
          hi_n    = '0;
          lo_n    = '0;
        end else begin
          lo_n = lo_cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        hi_n    = '0;
        lo_n    = '0;
      end
    endcase
  end

endmodule
